// File: rtl/rd_arb_pkg.sv
// Shared types and constants for the image-buffer read-port arbiter.
// Build option: define RD_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration
// instead of round-robin.
package rd_arb_pkg;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 8;
    localparam int MAX_REQ = 4;
    // Wide enough to count up to the largest allowed burst length (16).
    localparam int BURST_W = 5;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    // One in-flight read: whether it is real and which requester owns it.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } tag_t;

    // Next requester index, wrapping at the number of requesters.
    function automatic logic [1:0] wrap_inc(input logic [1:0] i, input int n);
        if (int'(i) + 1 >= n) begin
            return 2'd0;
        end
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/rd_port_arbiter_rr_pick.sv
// Combinational requester picker for the read-port arbiter.
// Default: first valid requester at or after ptr, wrapping.
// With RD_ARB_FIXED_PRIO_EN defined: lowest-index valid requester, ptr ignored.
module rr_pick #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [1:0]         ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [1:0]         grant_idx,
    output logic               grant_any
);

    // Scan requesters and report the winner as index plus one-hot.
    always_comb begin
        grant_oh  = '0;
        grant_idx = 2'd0;
        grant_any = 1'b0;
`ifdef RD_ARB_FIXED_PRIO_EN
        // Scan downward so the last hit is the lowest index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i]) begin
                grant_idx = 2'(i);
                grant_any = 1'b1;
            end
        end
`else
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                // j is the candidate seen i steps after ptr, modulo NUM_REQ.
                if (!grant_any && valid[j] &&
                    ((int'(ptr) + i == j) || (int'(ptr) + i - NUM_REQ == j))) begin
                    grant_idx = 2'(j);
                    grant_any = 1'b1;
                end
            end
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_oh[k] = grant_any && (grant_idx == 2'(k));
        end
    end

endmodule

// File: rtl/rd_port_arbiter.sv
// Shares the single 16K x 8 image-buffer read port among NUM_REQ requesters.
// One read per cycle, bursts held up to MAX_BURST grants, responses routed
// back through a tag pipeline matched to the fixed read latency.
// Build option: RD_ARB_FIXED_PRIO_EN (handled inside rr_pick).
module rd_port_arbiter
    import rd_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int RD_LAT    = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [ADDR_W*NUM_REQ-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [ADDR_W-1:0]         o_R_ADDR,
    output logic                      o_R_EN,
    input  logic [DATA_W-1:0]         i_R_DATA,
    output logic [NUM_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]         o_rsp_data,
    output logic                      o_busy
);

    localparam int NSTAGE = RD_LAT + 1;

    arb_state_t         state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         owner_q, owner_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [ADDR_W-1:0]  r_addr_q, r_addr_d;
    logic               r_en_q, r_en_d;
    tag_t               tag_q [NSTAGE];
    tag_t               tag_d [NSTAGE];

    logic [NUM_REQ-1:0] pick_oh;
    logic [1:0]         pick_idx;
    logic               pick_any;
    logic [NUM_REQ-1:0] ready;
    logic [1:0]         grant_idx;
    logic [NUM_REQ-1:0] owner_oh;
    logic               owner_valid;
    logic [ADDR_W-1:0]  addr_sel;
    logic               accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .valid     (i_req_valid),
        .ptr       (rr_ptr_q),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .grant_any (pick_any)
    );

    // Decode the current owner and whether it is still requesting.
    always_comb begin
        owner_oh    = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == 2'(i));
            if (owner_oh[i] && i_req_valid[i]) begin
                owner_valid = 1'b1;
            end
        end
    end

    // Arbitration FSM next state, grant generation and tag-pipeline shift.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        burst_d   = burst_q;
        ready     = '0;
        grant_idx = 2'd0;
        unique case (state_q)
            ARB: begin
                if (pick_any) begin
                    ready     = pick_oh;
                    grant_idx = pick_idx;
                    owner_d   = pick_idx;
                    burst_d   = BURST_W'(1);
                    if (MAX_BURST > 1) begin
                        state_d = HOLD;
                    end else begin
                        rr_ptr_d = wrap_inc(pick_idx, NUM_REQ);
                    end
                end
            end
            HOLD: begin
                if (owner_valid && (burst_q < BURST_W'(MAX_BURST))) begin
                    ready     = owner_oh;
                    grant_idx = owner_q;
                    burst_d   = burst_q + BURST_W'(1);
                end else begin
                    // Rotation cycle: no grant, move the pointer past the owner.
                    state_d  = ARB;
                    rr_ptr_d = wrap_inc(owner_q, NUM_REQ);
                end
            end
            default: state_d = ARB;
        endcase

        // Grants only ever go to valid requesters, so any ready is an accept.
        accept   = |ready;
        addr_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ready[i]) begin
                addr_sel = i_req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        r_en_d   = accept;
        r_addr_d = accept ? addr_sel : r_addr_q;

        tag_d[0] = '{valid: accept, idx: grant_idx};
        for (int s = 1; s < NSTAGE; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // State, read-port and tag registers; reset discards in-flight reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_ptr_q <= 2'd0;
            owner_q  <= 2'd0;
            burst_q  <= '0;
            r_addr_q <= '0;
            r_en_q   <= 1'b0;
            for (int s = 0; s < NSTAGE; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            r_addr_q <= r_addr_d;
            r_en_q   <= r_en_d;
            for (int s = 0; s < NSTAGE; s++) begin
                tag_q[s] <= tag_d[s];
            end
        end
    end

    // Busy while any tag stage holds a read.
    always_comb begin
        o_busy = 1'b0;
        for (int s = 0; s < NSTAGE; s++) begin
            o_busy = o_busy | tag_q[s].valid;
        end
    end

    // Route the returning byte to the owner recorded in the last tag stage.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
        assign o_rsp_valid[gi] = tag_q[NSTAGE-1].valid &&
                                 (tag_q[NSTAGE-1].idx == 2'(gi));
    end

    assign o_req_ready = ready;
    assign o_R_ADDR    = r_addr_q;
    assign o_R_EN      = r_en_q;
    assign o_rsp_data  = i_R_DATA;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed bench for rd_port_arbiter: per-cycle grant patterns worked out by
// hand, a fixed-latency read-path model and an expected-response pipeline.
module tb_rd_port_arbiter;
    import rd_arb_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int RD_LAT    = 3;
    localparam int MAX_BURST = 4;
    localparam int LAT       = RD_LAT + 1;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        i_req_valid = '0;
    logic [ADDR_W*NUM_REQ-1:0] i_req_addr = '0;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [ADDR_W-1:0]         o_R_ADDR;
    logic                      o_R_EN;
    logic [DATA_W-1:0]         i_R_DATA;
    logic [NUM_REQ-1:0]        o_rsp_valid;
    logic [DATA_W-1:0]         o_rsp_data;
    logic                      o_busy;

    always #5 clk = ~clk;

    rd_port_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_addr  (i_req_addr),
        .o_req_ready (o_req_ready),
        .o_R_ADDR    (o_R_ADDR),
        .o_R_EN      (o_R_EN),
        .i_R_DATA    (i_R_DATA),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_data  (o_rsp_data),
        .o_busy      (o_busy)
    );

    // Image-buffer contents as a function of address.
    function automatic logic [7:0] mem_f(input logic [13:0] a);
        return a[7:0] ^ {a[13:8], 2'b10};
    endfunction

    // Read path: RD_LAT-cycle delay from o_R_ADDR to i_R_DATA.
    logic [13:0] rp [RD_LAT];
    always @(posedge clk) begin
        rp[0] <= o_R_ADDR;
        for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end
    assign i_R_DATA = mem_f(rp[RD_LAT-1]);

    int          checks = 0;
    int          errors = 0;
    int          cur [NUM_REQ];
    int          endv [NUM_REQ];
    int          mlo [NUM_REQ];
    int          mhi [NUM_REQ];
    int          cyc;
    logic        ev [LAT];
    int          ek [LAT];
    logic [13:0] ea [LAT];
    logic [13:0] last_addr;
    logic [1:0]  pat [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_req(input int k, input int b, input int e, input int lo, input int hi);
        cur[k]  = b;
        endv[k] = e;
        mlo[k]  = lo;
        mhi[k]  = hi;
    endtask

    // Requester k is valid while it has addresses left and is not masked.
    task automatic drive();
        for (int k = 0; k < NUM_REQ; k++) begin
            i_req_valid[k] = (cur[k] < endv[k]) && !((cyc >= mlo[k]) && (cyc < mhi[k]));
            i_req_addr[k*ADDR_W +: ADDR_W] = 14'(cur[k]);
        end
    endtask

    // One clock cycle: check all outputs against expectations, then advance.
    task automatic cycle(input logic [1:0] exp_rdy);
        logic [NUM_REQ-1:0] hs;
        logic [NUM_REQ-1:0] erv;
        logic               eb;
        drive();
        @(negedge clk);
        chk("ready", 32'(o_req_ready), 32'(exp_rdy));
        chk("r_en", 32'(o_R_EN), 32'(ev[0]));
        if (ev[0]) last_addr = ea[0];
        chk("r_addr", 32'(o_R_ADDR), 32'(last_addr));
        erv = ev[LAT-1] ? NUM_REQ'(1 << ek[LAT-1]) : '0;
        chk("rsp_valid", 32'(o_rsp_valid), 32'(erv));
        if (ev[LAT-1]) begin
            chk("rsp_data", 32'(o_rsp_data), 32'(mem_f(ea[LAT-1])));
            $display("rsp req%0d addr %h data %h", ek[LAT-1], ea[LAT-1], o_rsp_data);
        end
        eb = 1'b0;
        for (int i = 0; i < LAT; i++) eb = eb | ev[i];
        chk("busy", 32'(o_busy), 32'(eb));
        hs = i_req_valid & o_req_ready;
        for (int i = LAT - 1; i > 0; i--) begin
            ev[i] = ev[i-1];
            ek[i] = ek[i-1];
            ea[i] = ea[i-1];
        end
        ev[0] = (exp_rdy != 2'b00);
        ek[0] = exp_rdy[1] ? 1 : 0;
        ea[0] = 14'(cur[ek[0]]);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (hs[k]) cur[k]++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_pat(input int drain);
        for (int i = 0; i < pat.size(); i++) cycle(pat[i]);
        for (int i = 0; i < drain; i++) cycle(2'b00);
    endtask

    // One reset cycle with requesters idle, then check the reset values.
    task automatic do_reset();
        rst_n = 1'b0;
        cyc = 0;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 0, 0, 0, 0);
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            ev[i] = 1'b0;
            ek[i] = 0;
            ea[i] = '0;
        end
        last_addr = '0;
        @(negedge clk);
        chk("rst_ready", 32'(o_req_ready), 32'h0);
        chk("rst_r_addr", 32'(o_R_ADDR), 32'h0);
        chk("rst_r_en", 32'(o_R_EN), 32'h0);
        chk("rst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        chk("rst_busy", 32'(o_busy), 32'h0);
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    initial begin
        cyc = 0;
        for (int k = 0; k < NUM_REQ; k++) set_req(k, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Single requester: burst of 4, rotation gap, burst of 4.
        do_reset();
        set_req(0, 'h0000, 'h0008, 0, 0);
        pat = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        run_pat(LAT + 3);

        // Both requesters continuously valid.
        do_reset();
        set_req(0, 'h100, 'h108, 0, 0);
        set_req(1, 'h200, 'h208, 0, 0);
`ifdef RD_ARB_FIXED_PRIO_EN
        pat = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
`else
        pat = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0,
                2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
        run_pat(LAT + 3);

        // Owner drops valid after two grants; pointer wraps back to req0.
        do_reset();
        set_req(0, 'h10, 'h14, 2, 8);
        set_req(1, 'h20, 'h28, 0, 0);
        pat = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0,
                2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2, 2'd2};
        run_pat(LAT + 3);

        // Reset with three reads in flight, inside a req1 burst.
        do_reset();
        set_req(1, 'h30, 'h40, 0, 0);
        pat = '{2'd2, 2'd2, 2'd2};
        run_pat(0);
        do_reset();
        set_req(0, 'h40, 'h42, 0, 0);
        set_req(1, 'h50, 'h52, 0, 0);
        pat = '{2'd1, 2'd1, 2'd0, 2'd2, 2'd2};
        run_pat(LAT + 3);

        // Top-of-buffer addresses.
        do_reset();
        set_req(1, 'h3FFE, 'h4000, 0, 0);
        pat = '{2'd2, 2'd2};
        run_pat(LAT + 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
